// File: rtl/rsa_keygen_iterative_if.sv
// Start/done request bus for the iterative RSA key generator.
// The master drives the operands and start, and the slave returns the status and results.
interface rsa_keygen_iterative_if #(
   parameter int size = 55
);
   logic                st;
   logic [size-1:0]     p_in;
   logic [size-1:0]     q_in;
   logic [size-1:0]     e_in;
   logic                busy;
   logic                done;
   logic [2:0]          err;
   logic [2*size-1:0]   n;
   logic [size-1:0]     e;
   logic [2*size-1:0]   d;

   modport master (
      output st, p_in, q_in, e_in,
      input  busy, done, err, n, e, d
   );

   modport slave (
      input  st, p_in, q_in, e_in,
      output busy, done, err, n, e, d
   );
endinterface

// File: rtl/rsa_keygen_iterative.sv
// Iterative RSA key generator.
// It computes n = p*q and phi = (p-1)*(q-1) with a shift-add multiplier.
// It then validates the operands and derives d = e^-1 mod phi using an extended Euclid engine.
// The Euclid engine performs one restoring division per iteration.
module rsa_keygen_iterative #(
   parameter int size       = 55,
   parameter int max_cycles = 65535,
   parameter int cnt_w      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   rsa_keygen_iterative_if.slave bus
);
   localparam int w  = 2 * size;
   localparam int sw = $clog2(w + 1);

   typedef enum logic [2:0] {idle, mul, check, inv, post, finish} state_t;

   state_t                 state_reg;
   logic [size-1:0]        p_reg, q_reg, e_reg;
   logic [w-1:0]           mp_reg, mpm_reg;      // multiplicands p and p-1, shifted left each step
   logic [size-1:0]        mq_reg, mqm_reg;      // multipliers q and q-1, shifted right each step
   logic [w-1:0]           n_acc_reg, phi_reg;
   logic [sw-1:0]          step_reg;
   logic [cnt_w-1:0]       wd_reg;
   logic [w-1:0]           r0_reg, r1_reg, quo_reg, rem_reg;
   logic signed [w:0]      t0_reg, t1_reg, qt_reg;
   logic                   busy_reg, done_reg;
   logic [2:0]             err_reg;
   logic [w-1:0]           n_reg, d_reg;
   logic [size-1:0]        e_out_reg;

   logic [w:0]             rem_shift;
   logic                   rem_ge;
   logic [w-1:0]           rem_next;
   logic signed [w:0]      qt_next;
   logic                   bad_primes, bad_e, wd_last;

   // One restoring-division step, plus the MSB-first accumulation of q*t1, plus the operand checks.
   always_comb begin
      rem_shift  = {rem_reg, quo_reg[w-1]};
      rem_ge     = rem_shift >= {1'b0, r1_reg};
      rem_next   = rem_ge ? w'(rem_shift - {1'b0, r1_reg}) : rem_shift[w-1:0];
      qt_next    = (qt_reg <<< 1) + (rem_ge ? t1_reg : '0);
      bad_primes = (p_reg < size'(3)) || (q_reg < size'(3)) || (p_reg == q_reg);
      bad_e      = !e_reg[0] || (e_reg < size'(3)) || ({{size{1'b0}}, e_reg} >= phi_reg);
      wd_last    = (wd_reg == cnt_w'(max_cycles - 1));
   end

   // Control FSM and datapath. Results are registered on the way into finish.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= idle;
         p_reg     <= '0;  q_reg   <= '0;  e_reg    <= '0;
         mp_reg    <= '0;  mpm_reg <= '0;  mq_reg   <= '0;  mqm_reg <= '0;
         n_acc_reg <= '0;  phi_reg <= '0;  step_reg <= '0;  wd_reg  <= '0;
         r0_reg    <= '0;  r1_reg  <= '0;  quo_reg  <= '0;  rem_reg <= '0;
         t0_reg    <= '0;  t1_reg  <= '0;  qt_reg   <= '0;
         busy_reg  <= 1'b0; done_reg <= 1'b0; err_reg <= '0;
         n_reg     <= '0;  d_reg   <= '0;  e_out_reg <= '0;
      end else begin
         case (state_reg)
            idle: begin
               if (bus.st) begin
                  p_reg     <= bus.p_in;
                  q_reg     <= bus.q_in;
                  e_reg     <= bus.e_in;
                  mp_reg    <= {{size{1'b0}}, bus.p_in};
                  mpm_reg   <= {{size{1'b0}}, bus.p_in - size'(1)};
                  mq_reg    <= bus.q_in;
                  mqm_reg   <= bus.q_in - size'(1);
                  n_acc_reg <= '0;
                  phi_reg   <= '0;
                  step_reg  <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= mul;
               end
            end
            mul: begin
               n_acc_reg <= n_acc_reg + (mq_reg[0]  ? mp_reg  : '0);
               phi_reg   <= phi_reg   + (mqm_reg[0] ? mpm_reg : '0);
               mp_reg    <= mp_reg  << 1;
               mpm_reg   <= mpm_reg << 1;
               mq_reg    <= mq_reg  >> 1;
               mqm_reg   <= mqm_reg >> 1;
               step_reg  <= step_reg + 1'b1;
               if (step_reg == sw'(size - 1)) state_reg <= check;
            end
            check: begin
               if (bad_primes || bad_e) begin
                  err_reg   <= bad_primes ? 3'd1 : 3'd2;
                  d_reg     <= '0;
                  n_reg     <= n_acc_reg;
                  e_out_reg <= e_reg;
                  done_reg  <= 1'b1;
                  state_reg <= finish;
               end else begin
                  r0_reg    <= phi_reg;
                  r1_reg    <= {{size{1'b0}}, e_reg};
                  t0_reg    <= '0;
                  t1_reg    <= (w+1)'(1);
                  quo_reg   <= phi_reg;
                  rem_reg   <= '0;
                  qt_reg    <= '0;
                  step_reg  <= '0;
                  wd_reg    <= '0;
                  state_reg <= inv;
               end
            end
            inv: begin
               wd_reg <= wd_reg + 1'b1;
               if (wd_last) begin
                  err_reg   <= 3'd4;
                  d_reg     <= '0;
                  n_reg     <= n_acc_reg;
                  e_out_reg <= e_reg;
                  done_reg  <= 1'b1;
                  state_reg <= finish;
               end else if (step_reg == sw'(w)) begin
                  // Division finished: rem_reg = r0 mod r1, qt_reg = q*t1
                  r0_reg   <= r1_reg;
                  r1_reg   <= rem_reg;
                  t0_reg   <= t1_reg;
                  t1_reg   <= t0_reg - qt_reg;
                  quo_reg  <= r1_reg;
                  rem_reg  <= '0;
                  qt_reg   <= '0;
                  step_reg <= '0;
                  if (rem_reg == '0) state_reg <= post;
               end else begin
                  rem_reg  <= rem_next;
                  quo_reg  <= {quo_reg[w-2:0], rem_ge};
                  qt_reg   <= qt_next;
                  step_reg <= step_reg + 1'b1;
               end
            end
            post: begin
               // r0 now holds gcd(e, phi); t0 is the Bezout coefficient of e
               if (r0_reg != w'(1)) begin
                  err_reg <= 3'd3;
                  d_reg   <= '0;
               end else begin
                  err_reg <= 3'd0;
                  d_reg   <= t0_reg[w] ? w'(t0_reg + $signed({1'b0, phi_reg})) : t0_reg[w-1:0];
               end
               n_reg     <= n_acc_reg;
               e_out_reg <= e_reg;
               done_reg  <= 1'b1;
               state_reg <= finish;
            end
            finish: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= idle;
            end
            default: state_reg <= idle;
         endcase
      end
   end

   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
   assign bus.err  = err_reg;
   assign bus.n    = n_reg;
   assign bus.e    = e_out_reg;
   assign bus.d    = d_reg;
endmodule

// File: tb/tb_rsa_keygen_iterative.sv
// Self-checking bench for rsa_keygen_iterative.
// It uses directed cases and random prime pairs, checked against an arithmetic reference model.
module tb_rsa_keygen_iterative;
   localparam int size = 55;
   localparam int w    = 2 * size;

   logic clk = 1'b0;
   logic reset;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   rsa_keygen_iterative_if #(.size(size)) bus ();
   rsa_keygen_iterative_if #(.size(size)) bus_to ();

   rsa_keygen_iterative #(.size(size)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );
   rsa_keygen_iterative #(.size(size), .max_cycles(50), .cnt_w(16)) dut_to (
      .clk(clk), .reset(reset), .bus(bus_to.slave)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit is_prime(input int unsigned x);
      if (x < 2) return 0;
      for (int unsigned k = 2; k * k <= x; k++)
         if (x % k == 0) return 0;
      return 1;
   endfunction

   function automatic int unsigned next_prime(input int unsigned x);
      int unsigned y;
      y = x;
      while (!is_prime(y)) y++;
      return y;
   endfunction

   function automatic logic [127:0] gcd128(input logic [127:0] a_in, input logic [127:0] b_in);
      logic [127:0] a, b, t;
      a = a_in; b = b_in;
      while (b != 0) begin t = a % b; a = b; b = t; end
      return a;
   endfunction

   // Modular inverse by textbook extended Euclid. Also returns the number of division steps.
   function automatic void inv_model(input logic [127:0] phi, input logic [127:0] ev,
                                     output logic [127:0] d, output int iters);
      logic signed [129:0] a, b, ta, tb, qq, tmp;
      a = $signed({2'b00, phi}); b = $signed({2'b00, ev});
      ta = 0; tb = 1; iters = 0;
      while (b != 0) begin
         qq = a / b;
         tmp = a - qq * b;  a = b;   b = tmp;
         tmp = ta - qq * tb; ta = tb; tb = tmp;
         iters++;
      end
      if (ta < 0) ta = ta + $signed({2'b00, phi});
      d = ta[127:0];
   endfunction

   function automatic logic [2:0] err_model(input logic [127:0] p, input logic [127:0] q,
                                            input logic [127:0] ev, input logic [127:0] phi);
      if (p < 3 || q < 3 || p == q) return 3'd1;
      if (!ev[0] || ev < 3 || ev >= phi) return 3'd2;
      if (gcd128(ev, phi) != 1) return 3'd3;
      return 3'd0;
   endfunction

   // Runs one request and checks every output against the model.
   // If poke > 0, a second start is issued while the block is busy.
   // If st_on_done is set, a start is issued during the done cycle.
   task automatic do_case(input string tag, input logic [127:0] p, input logic [127:0] q,
                          input logic [127:0] ev, input int poke, input bit st_on_done);
      logic [127:0] n_exp, phi, d_exp;
      logic [2:0]   err_exp;
      int           iters, lat, exp_lat;
      bit           seen;
      n_exp = p * q;
      phi   = (p - 1) * (q - 1);
      err_exp = err_model(p, q, ev, phi);
      d_exp = 0; iters = 0;
      if (err_exp == 0 || err_exp == 3) inv_model(phi, ev, d_exp, iters);
      if (err_exp != 0) d_exp = 0;
      exp_lat = 1 + size + 1 + iters * (2 * size + 1) + 1 + 1;

      @(negedge clk);
      bus.st = 1'b1; bus.p_in = p[size-1:0]; bus.q_in = q[size-1:0]; bus.e_in = ev[size-1:0];
      lat = 1; seen = 0;
      for (int c = 0; c < 30000; c++) begin
         @(negedge clk);
         lat++;
         if (c == 0) begin
            bus.st = 1'b0;
            bus.p_in = size'($urandom); bus.q_in = size'($urandom); bus.e_in = size'($urandom);
            check({tag, "_busy"}, bus.busy, 1);
         end
         if (poke > 0 && c == poke) begin
            bus.st = 1'b1; bus.p_in = 3; bus.q_in = 11; bus.e_in = 3;
         end
         if (poke > 0 && c == poke + 1) bus.st = 1'b0;
         if (bus.done) begin seen = 1; break; end
      end
      check({tag, "_done_seen"}, seen, 1);
      check({tag, "_err"}, bus.err, err_exp);
      check({tag, "_n"}, bus.n, n_exp);
      check({tag, "_e"}, bus.e, ev);
      check({tag, "_d"}, bus.d, d_exp);
      if (err_exp == 0) begin
         check({tag, "_de_mod"}, (128'(bus.d) * 128'(bus.e)) % phi, 1);
         check({tag, "_d_lt_phi"}, 128'(bus.d) < phi, 1);
      end
      if (err_exp == 0 || err_exp == 3) check({tag, "_latency"}, lat, exp_lat);
      $display("[TB] %s p=%0d q=%0d e=%0d -> err=%0d n=%0d d=%0d latency=%0d",
               tag, p, q, ev, bus.err, bus.n, bus.d, lat);
      if (st_on_done) begin
         bus.st = 1'b1; bus.p_in = 61; bus.q_in = 53; bus.e_in = 17;
      end
      @(negedge clk);
      bus.st = 1'b0;
      check({tag, "_done_pulse"}, bus.done, 0);
      check({tag, "_busy_after"}, bus.busy, 0);
   endtask

   // Global guard so a stuck design still produces a summary.
   initial begin
      #3ms;
      $display("FAIL global_timeout: got no finish expected finish");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1);
   end

   initial begin
      int lat;
      bit seen;
      int unsigned pr, qr, er;
      logic [127:0] ph;

      reset = 1'b0;
      bus.st = 1'b0; bus.p_in = '0; bus.q_in = '0; bus.e_in = '0;
      bus_to.st = 1'b0; bus_to.p_in = '0; bus_to.q_in = '0; bus_to.e_in = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_n", bus.n, 0);
      check("rst_e", bus.e, 0);
      check("rst_d", bus.d, 0);
      reset = 1'b1;

      do_case("nominal", 61, 53, 17, 0, 0);
      do_case("small", 3, 11, 3, 0, 1);
      do_case("large", 128'h7FFF_FFFF, 65537, 65537, 0, 0);
      do_case("bad_primes", 13, 13, 17, 0, 0);
      do_case("bad_e", 7, 13, 4, 0, 0);
      do_case("gcd", 7, 13, 3, 0, 0);
      do_case("st_busy", 61, 53, 17, 20, 0);

      // Watchdog instance: 50 INV cycles, then abort
      @(negedge clk);
      bus_to.st = 1'b1; bus_to.p_in = 61; bus_to.q_in = 53; bus_to.e_in = 17;
      lat = 1; seen = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         lat++;
         if (c == 0) bus_to.st = 1'b0;
         if (bus_to.done) begin seen = 1; break; end
      end
      check("to_done_seen", seen, 1);
      check("to_err", bus_to.err, 4);
      check("to_d", bus_to.d, 0);
      check("to_n", bus_to.n, 3233);
      check("to_latency", lat, 1 + size + 1 + 50 + 1);
      $display("[TB] timeout p=61 q=53 e=17 -> err=%0d latency=%0d", bus_to.err, lat);

      // Reset in the middle of INV
      @(negedge clk);
      bus.st = 1'b1; bus.p_in = 61; bus.q_in = 53; bus.e_in = 17;
      @(negedge clk);
      bus.st = 1'b0;
      repeat (100) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      check("midrst_err", bus.err, 0);
      check("midrst_n", bus.n, 0);
      check("midrst_e", bus.e, 0);
      check("midrst_d", bus.d, 0);
      $display("[TB] reset mid-INV -> busy=%0d n=%0d", bus.busy, bus.n);
      do_case("after_rst", 61, 53, 17, 0, 0);

      // Reset together with st in IDLE must not capture
      @(negedge clk);
      reset = 1'b0; bus.st = 1'b1; bus.p_in = 61; bus.q_in = 53; bus.e_in = 17;
      @(negedge clk);
      reset = 1'b1; bus.st = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_st_busy", bus.busy, 0);
      check("rst_st_n", bus.n, 0);
      $display("[TB] reset with st -> busy=%0d", bus.busy);

      // Random prime pairs and odd exponents
      for (int k = 0; k < 12; k++) begin
         pr = next_prime($urandom_range(3, 4000));
         qr = next_prime($urandom_range(3, 4000));
         ph = 128'(pr - 1) * 128'(qr - 1);
         er = $urandom_range(3, (ph > 4) ? 32'(ph - 1) : 3) | 32'd1;
         do_case("rand", 128'(pr), 128'(qr), 128'(er), 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
